// File: rtl/dut_sweep_capture.sv
// Sweep driver and bit collector for a combinational DUT: drives each stimulus vector,
// walks the bit-select through every result bit and hands the rebuilt word to a valid/ready sink.
module dut_sweep_capture #(
  parameter int RESULT_WIDTH  = 32,
  parameter int SETTLE_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_input,
  input  logic [15:0] vector_count,
  output logic        busy,
  output logic        done,
  output logic [31:0] dut_input,
  output logic [31:0] dut_signal_select,
  input  logic        dut_output,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result_data,
  output logic [31:0] result_input
);

  localparam int SEL_W = (RESULT_WIDTH > 1) ? $clog2(RESULT_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_EMIT
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SEL_W-1:0]        r_sel;
  logic [3:0]              r_settle;
  logic [15:0]             r_remaining;
  logic [RESULT_WIDTH-1:0] r_shadow;
  logic [RESULT_WIDTH-1:0] w_shadow_nxt;
  logic [31:0]             r_dut_input;
  logic [31:0]             r_result_data;
  logic [31:0]             r_result_input;
  logic                    r_done;

  logic w_sample;
  logic w_last_bit;
  logic w_more;

  assign w_sample   = (r_state == S_SCAN) && (r_settle == 4'(SETTLE_CYCLES));
  assign w_last_bit = (r_sel == SEL_W'(RESULT_WIDTH - 1));
  assign w_more     = (r_remaining != 16'd1);

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    w_shadow_nxt        = r_shadow;
    w_shadow_nxt[r_sel] = dut_output;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && (vector_count != 16'd0)) w_state_nxt = S_SCAN;
      S_SCAN:  if (w_sample && w_last_bit) w_state_nxt = S_EMIT;
      S_EMIT:  if (result_ready) w_state_nxt = w_more ? S_SCAN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_sel          <= '0;
      r_settle       <= '0;
      r_remaining    <= '0;
      r_shadow       <= '0;
      r_dut_input    <= '0;
      r_result_data  <= '0;
      r_result_input <= '0;
      r_done         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (vector_count != 16'd0) begin
              r_dut_input <= base_input;
              r_sel       <= '0;
              r_settle    <= '0;
              r_remaining <= vector_count;
              r_shadow    <= '0;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_SCAN: begin
          if (w_sample) begin
            r_settle <= '0;
            r_shadow <= w_shadow_nxt;
            // The select parks on the last bit so it never leaves 0..RESULT_WIDTH-1.
            if (w_last_bit) begin
              r_result_data  <= 32'(w_shadow_nxt);
              r_result_input <= r_dut_input;
            end else begin
              r_sel <= r_sel + SEL_W'(1);
            end
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end
        S_EMIT: begin
          if (result_ready) begin
            r_remaining <= r_remaining - 16'd1;
            if (w_more) begin
              r_dut_input <= r_dut_input + 32'd1;
              r_sel       <= '0;
              r_settle    <= '0;
              r_shadow    <= '0;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy              = (r_state != S_IDLE);
  assign done              = r_done;
  assign result_valid      = (r_state == S_EMIT);
  assign dut_input         = r_dut_input;
  assign dut_signal_select = 32'(r_sel);
  assign result_data       = r_result_data;
  assign result_input      = r_result_input;

endmodule

// File: tb/tb_dut_sweep_capture.sv
// Bench for dut_sweep_capture: three instances (wide, wide with settle, narrow) sweeping a
// half-word adder, each word checked against an arithmetic reference model.
module tb_dut_sweep_capture;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        st[3];
  logic [31:0] bs[3];
  logic [15:0] vc[3];
  logic        rdy[3];
  logic        bsy[3], dn[3], vld[3], dout[3];
  logic [31:0] din[3], dsel[3], rdata[3], rin[3];

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] got[$];

  function automatic int rw_of(input int k);
    return (k == 2) ? 8 : 32;
  endfunction

  function automatic int settle_of(input int k);
    case (k)
      0:       return 0;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  // Device being swept: upper half-word plus lower half-word, 17-bit sum.
  function automatic logic [31:0] add_halves(input logic [31:0] x);
    return {16'd0, x[31:16]} + {16'd0, x[15:0]};
  endfunction

  function automatic logic bit_of(input logic [31:0] x, input logic [31:0] sel);
    logic [31:0] w;
    w = add_halves(x);
    return (sel < 32) ? w[sel[4:0]] : 1'b0;
  endfunction

  function automatic logic [31:0] model_word(input int k, input logic [31:0] x);
    logic [31:0] s;
    s = add_halves(x);
    if (rw_of(k) < 32) s = s & ((32'd1 << rw_of(k)) - 32'd1);
    return s;
  endfunction

  always_comb for (int k = 0; k < 3; k++) dout[k] = bit_of(din[k], dsel[k]);

  dut_sweep_capture #(.RESULT_WIDTH(32), .SETTLE_CYCLES(0)) u_wide (
    .clk(clk), .reset(reset), .start(st[0]), .base_input(bs[0]), .vector_count(vc[0]),
    .busy(bsy[0]), .done(dn[0]), .dut_input(din[0]), .dut_signal_select(dsel[0]),
    .dut_output(dout[0]), .result_valid(vld[0]), .result_ready(rdy[0]),
    .result_data(rdata[0]), .result_input(rin[0]));

  dut_sweep_capture #(.RESULT_WIDTH(32), .SETTLE_CYCLES(2)) u_settle (
    .clk(clk), .reset(reset), .start(st[1]), .base_input(bs[1]), .vector_count(vc[1]),
    .busy(bsy[1]), .done(dn[1]), .dut_input(din[1]), .dut_signal_select(dsel[1]),
    .dut_output(dout[1]), .result_valid(vld[1]), .result_ready(rdy[1]),
    .result_data(rdata[1]), .result_input(rin[1]));

  dut_sweep_capture #(.RESULT_WIDTH(8), .SETTLE_CYCLES(1)) u_narrow (
    .clk(clk), .reset(reset), .start(st[2]), .base_input(bs[2]), .vector_count(vc[2]),
    .busy(bsy[2]), .done(dn[2]), .dut_input(din[2]), .dut_signal_select(dsel[2]),
    .dut_output(dout[2]), .result_valid(vld[2]), .result_ready(rdy[2]),
    .result_data(rdata[2]), .result_input(rin[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete sweep on instance k; first_stall < 0 means random backpressure.
  task automatic run_sweep(input int k, input logic [31:0] base, input int count,
                           input int first_stall);
    int          per;
    int          stall;
    logic [31:0] cur;
    per = settle_of(k) + 1;
    cur = base;
    @(negedge clk);
    st[k] = 1'b1; bs[k] = base; vc[k] = 16'(count);
    @(negedge clk);
    st[k] = 1'b0; bs[k] = $urandom; vc[k] = 16'($urandom);
    if (count == 0) begin
      check("zero_done", 32'(dn[k]), 32'd1);
      check("zero_busy", 32'(bsy[k]), 32'd0);
      check("zero_valid", 32'(vld[k]), 32'd0);
      @(negedge clk);
      check("zero_done_off", 32'(dn[k]), 32'd0);
      check("zero_busy_off", 32'(bsy[k]), 32'd0);
      return;
    end
    for (int v = 0; v < count; v++) begin
      for (int i = 0; i < rw_of(k) * per; i++) begin
        check("scan_busy", 32'(bsy[k]), 32'd1);
        check("scan_valid", 32'(vld[k]), 32'd0);
        check("scan_done", 32'(dn[k]), 32'd0);
        check("scan_select", dsel[k], 32'(i / per));
        check("scan_input", din[k], cur);
        rdy[k] = 1'($urandom);
        st[k]  = 1'($urandom);
        bs[k]  = $urandom;
        @(negedge clk);
      end
      stall = (v == 0 && first_stall >= 0) ? first_stall : int'($urandom_range(0, 3));
      for (int j = 0; j <= stall; j++) begin
        check("emit_valid", 32'(vld[k]), 32'd1);
        check("emit_data", rdata[k], model_word(k, cur));
        check("emit_input", rin[k], cur);
        check("emit_done", 32'(dn[k]), 32'd0);
        if (j == 0) got.push_back(rdata[k]);
        rdy[k] = (j == stall);
        st[k]  = 1'($urandom);
        @(negedge clk);
      end
      cur = cur + 32'd1;
    end
    st[k] = 1'b0; rdy[k] = 1'b0;
    check("end_done", 32'(dn[k]), 32'd1);
    check("end_busy", 32'(bsy[k]), 32'd0);
    check("end_valid", 32'(vld[k]), 32'd0);
    @(negedge clk);
    check("end_done_off", 32'(dn[k]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; bs[k] = '0; vc[k] = '0; rdy[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rst_busy", 32'(bsy[k]), 32'd0);
      check("rst_done", 32'(dn[k]), 32'd0);
      check("rst_valid", 32'(vld[k]), 32'd0);
      check("rst_dut_input", din[k], 32'd0);
      check("rst_select", dsel[k], 32'd0);
      check("rst_data", rdata[k], 32'd0);
    end

    got.delete();
    run_sweep(0, 32'h0003_0005, 1, 0);
    check("basic_word", got[0], 32'h0000_0008);

    got.delete();
    run_sweep(0, 32'hFFFF_FFFF, 2, -1);
    check("carry_word", got[0], 32'h0001_FFFE);
    check("wrap_word", got[1], 32'h0000_0000);

    got.delete();
    run_sweep(1, 32'h0001_0001, 2, 10);
    check("stall_word", got[0], 32'h0000_0002);

    run_sweep(0, 32'h1234_5678, 0, -1);
    run_sweep(0, $urandom, 3, -1);

    // Reset while scanning select 12 of a three-vector sweep.
    @(negedge clk);
    st[0] = 1'b1; bs[0] = $urandom; vc[0] = 16'd3;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_reset_select", dsel[0], 32'd12);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 32'(bsy[0]), 32'd0);
    check("mid_rst_done", 32'(dn[0]), 32'd0);
    check("mid_rst_valid", 32'(vld[0]), 32'd0);
    check("mid_rst_dut_input", din[0], 32'd0);
    check("mid_rst_select", dsel[0], 32'd0);
    check("mid_rst_data", rdata[0], 32'd0);
    check("mid_rst_input", rin[0], 32'd0);
    @(negedge clk);
    check("post_rst_done", 32'(dn[0]), 32'd0);
    check("post_rst_busy", 32'(bsy[0]), 32'd0);
    run_sweep(0, $urandom, 2, -1);

    got.delete();
    run_sweep(2, 32'h00FF_00FF, 1, -1);
    check("narrow_word", got[0], 32'h0000_00FE);

    for (int n = 0; n < 6; n++) begin
      run_sweep(int'($urandom_range(0, 2)), $urandom, int'($urandom_range(1, 3)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
